// File: rtl/fetch_decode_ctrl.sv
// IF/ID pipeline register controller: capture, hold on load-use, kill on redirect, valid/ready to fetch and decode.
// Optional FD_PERF_CNT_EN adds saturating stall/flush event counters.
module fetch_decode_ctrl #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     FLUSH_CYCLES = 1,
  parameter logic [XLEN-1:0] NOP_INSTR    = XLEN'(32'h00000013)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            f_valid_i,
  input  logic [XLEN-1:0] f_instruction_i,
  input  logic [XLEN-1:0] f_pc_i,
  output logic            f_ready_o,
  input  logic            d_ready_i,
  output logic            fd_valid_o,
  output logic [XLEN-1:0] fd_instruction_o,
  output logic [XLEN-1:0] fd_pc_o,
  output logic            fd_bubble_o,
  input  logic            ex_mem_read_i,
  input  logic [4:0]      ex_rd_i,
`ifdef FD_PERF_CNT_EN
  output logic [31:0]     stall_cnt_o,
  output logic [31:0]     flush_cnt_o,
`endif
  input  logic            redirect_i
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
    $error("fetch_decode_ctrl: FLUSH_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {S_EMPTY, S_VALID, S_STALL, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              hazard;

  assign fd_valid_o       = (state_q == S_VALID) || (state_q == S_STALL);
  assign fd_instruction_o = instr_q;
  assign fd_pc_o          = pc_q;

  // Both rs fields are compared regardless of opcode; a false stall only costs a cycle.
  assign hazard = fd_valid_o && ex_mem_read_i && (ex_rd_i != 5'd0) &&
                  ((ex_rd_i == instr_q[19:15]) || (ex_rd_i == instr_q[24:20]));

  assign fd_bubble_o = hazard && !redirect_i && (state_q != S_STALL);
  assign f_ready_o   = !rst_i && ((state_q == S_FLUSH) ||
                       ((state_q != S_STALL) && !hazard && (!fd_valid_o || d_ready_i)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_EMPTY;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (redirect_i) begin
      // Kill whatever is in the register and any word fetch offers this cycle; PC is left as-is.
      state_d = S_FLUSH;
      instr_d = NOP_INSTR;
      cnt_d   = 4'(FLUSH_CYCLES);
    end else begin
      unique case (state_q)
        S_FLUSH: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = S_EMPTY;
        end
        S_STALL: state_d = S_VALID;
        default: begin
          if (f_valid_i && f_ready_o) begin
            state_d = S_VALID;
            instr_d = f_instruction_i;
            pc_d    = f_pc_i;
          end else if (hazard) begin
            state_d = S_STALL;
          end else if (fd_valid_o && d_ready_i) begin
            state_d = S_EMPTY;
            instr_d = NOP_INSTR;
          end
        end
      endcase
    end
  end

`ifdef FD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        stall_enter;

  assign stall_enter = (state_q == S_VALID) && hazard && !redirect_i;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_enter && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redirect_i && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end
`endif

endmodule
